// File: rtl/memshare_rank_pkg.sv
// Shared types and sizing helpers for the VN IB-LUT rank.
// Lane depth depends on whether the lane carries one or two col-sel bits.
package memshare_rank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } rank_state_t;

    localparam int DEF_NUM_LANE = 4;
    localparam int DEF_MSG_WIDTH = 4;
    localparam int DEF_BANK_NUM = 4;
    localparam logic [3:0] DEF_LANE_CFG = 4'b1010;

    function automatic int lane_depth(input logic cfg_bit, input int msg_width);
        return cfg_bit ? (1 << (msg_width + 2)) : (1 << (msg_width + 1));
    endfunction

    function automatic int rank_depth_max(
        input logic [31:0] cfg,
        input int num_lane,
        input int msg_width
    );
        int d;
        d = 0;
        for (int i = 0; i < num_lane; i++) begin
            if (lane_depth(cfg[i], msg_width) > d) begin
                d = lane_depth(cfg[i], msg_width);
            end
        end
        return d;
    endfunction

    localparam int D_MAX = rank_depth_max(32'(DEF_LANE_CFG), DEF_NUM_LANE, DEF_MSG_WIDTH);
    localparam int BEAT_NUM = D_MAX / DEF_BANK_NUM;

endpackage

// File: rtl/memshare_iblut_lane.sv
// One VN lane LUT: bank-interleaved remap writes, pipelined reads.
// Writes past this lane's depth are dropped so GP1 lanes skip late beats.
module memshare_iblut_lane
    import memshare_rank_pkg::*;
#(
    parameter bit GP2 = 1'b0,
    parameter int DEPTH = 32,
    parameter int MSG_WIDTH = 4,
    parameter int SEL_WIDTH = 2,
    parameter int BANK_NUM = 4,
    parameter int READ_LAT = 2,
    parameter int BEAT_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [BEAT_W-1:0]             beat_cnt,
    input  logic [MSG_WIDTH*BANK_NUM-1:0] wr_data,
    input  logic                          rd_en,
    input  logic [SEL_WIDTH-1:0]          rd_sel,
    input  logic [MSG_WIDTH-1:0]          rd_msg,
    output logic [MSG_WIDTH-1:0]          rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int BK_SH = $clog2(BANK_NUM);
    localparam int FW = BEAT_W + BK_SH + 1;

    logic [MSG_WIDTH-1:0] mem [DEPTH];
    logic [MSG_WIDTH-1:0] pipe [READ_LAT];
    logic [FW-1:0]        wa [BANK_NUM];
    logic [AW-1:0]        ra;

    for (genvar k = 0; k < BANK_NUM; k++) begin : g_wa
        assign wa[k] = (FW'(beat_cnt) << BK_SH) | FW'(k);
    end

    if (GP2) begin : g_gp2
        assign ra = AW'({rd_sel[1:0], rd_msg});
    end else begin : g_gp1
        assign ra = AW'({rd_sel[0], rd_msg});
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < BANK_NUM; k++) begin
            if (wr_en && (wa[k] < FW'(DEPTH))) begin
                mem[wa[k][AW-1:0]] <= wr_data[k*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end

    // Data is captured at acceptance, so later remap writes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (rd_en) begin
                pipe[0] <= mem[ra];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rd_data = pipe[READ_LAT-1];

endmodule

// File: rtl/memshare_vn_iblut_rank.sv
// Rank of VN IB-LUT lanes with a handshaked remap loader and a
// pipelined valid/ready read path; loads lock out new reads.
module memshare_vn_iblut_rank_seq
    import memshare_rank_pkg::*;
#(
    parameter int NUM_LANE = DEF_NUM_LANE,
    parameter int MSG_WIDTH = DEF_MSG_WIDTH,
    parameter int GP2_COL_SEL_WIDTH = 2,
    parameter logic [NUM_LANE-1:0] LANE_CFG = DEF_LANE_CFG,
    parameter int BANK_NUM = DEF_BANK_NUM,
    parameter int READ_LAT = 2
) (
    input  logic                                   sys_clk,
    input  logic                                   rst,
    input  logic                                   rd_valid_i,
    output logic                                   rd_ready_o,
    input  logic [NUM_LANE*GP2_COL_SEL_WIDTH-1:0]  col_sel_vec_i,
    input  logic [NUM_LANE*MSG_WIDTH-1:0]          c2v_msg_vec_i,
    output logic [NUM_LANE*MSG_WIDTH-1:0]          v2c_msg_vec_o,
    output logic                                   v2c_valid_o,
    input  logic                                   remap_start_i,
    input  logic                                   remap_abort_i,
    input  logic                                   remap_valid_i,
    output logic                                   remap_ready_o,
    input  logic [NUM_LANE*MSG_WIDTH*BANK_NUM-1:0] remap_data_vec_i,
    output logic                                   remap_busy_o,
    output logic                                   remap_done_o
);

    localparam int DMAX = rank_depth_max(32'(LANE_CFG), NUM_LANE, MSG_WIDTH);
    localparam int NBEAT = DMAX / BANK_NUM;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int BW = MSG_WIDTH * BANK_NUM;
    localparam int SW = GP2_COL_SEL_WIDTH;

    rank_state_t         state;
    rank_state_t         state_nxt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [READ_LAT-1:0] rd_vld;
    logic                beat_last;
    logic                beat_fire;
    logic                wr_en;
    logic                rd_fire;

    assign beat_last = (beat_cnt == BEAT_W'(NBEAT - 1));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rd_ready_o    = 1'b0;
        remap_ready_o = 1'b0;
        remap_busy_o  = 1'b0;
        remap_done_o  = 1'b0;
        beat_fire     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                rd_ready_o = !remap_start_i;
                if (remap_start_i) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                remap_ready_o = 1'b1;
                remap_busy_o  = 1'b1;
                if (remap_abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (remap_valid_i) begin
                    beat_fire = 1'b1;
                    if (beat_last) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                remap_done_o = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_en   = beat_fire && !rst;
    assign rd_fire = rd_valid_i && rd_ready_o;

    // Counter only survives while the loader stays in LOAD.
    always_ff @(posedge sys_clk) begin
        if (rst || (state_nxt != ST_LOAD)) begin
            beat_cnt <= '0;
        end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= rd_fire;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end
        end
    end

    assign v2c_valid_o = rd_vld[READ_LAT-1];

    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
        memshare_iblut_lane #(
            .GP2       (LANE_CFG[i]),
            .DEPTH     (lane_depth(LANE_CFG[i], MSG_WIDTH)),
            .MSG_WIDTH (MSG_WIDTH),
            .SEL_WIDTH (SW),
            .BANK_NUM  (BANK_NUM),
            .READ_LAT  (READ_LAT),
            .BEAT_W    (BEAT_W)
        ) u_lane (
            .clk      (sys_clk),
            .rst      (rst),
            .wr_en    (wr_en),
            .beat_cnt (beat_cnt),
            .wr_data  (remap_data_vec_i[i*BW +: BW]),
            .rd_en    (rd_fire),
            .rd_sel   (col_sel_vec_i[i*SW +: SW]),
            .rd_msg   (c2v_msg_vec_i[i*MSG_WIDTH +: MSG_WIDTH]),
            .rd_data  (v2c_msg_vec_o[i*MSG_WIDTH +: MSG_WIDTH])
        );
    end

endmodule

// File: tb/tb_memshare_vn_iblut_rank_seq.sv
// Randomized directed bench for the VN IB-LUT rank with a
// behavioural LUT model and a read-latency scoreboard.
module tb_memshare_vn_iblut_rank_seq;

    localparam int NL = 4;
    localparam int MW = 4;
    localparam int BK = 4;
    localparam int RL = 2;
    localparam int NBEAT = 16;
    localparam bit [3:0] CFG = 4'b1010;

    logic               sys_clk;
    logic               rst;
    logic               rd_valid_i;
    logic               rd_ready_o;
    logic [NL*2-1:0]    col_sel_vec_i;
    logic [NL*MW-1:0]   c2v_msg_vec_i;
    logic [NL*MW-1:0]   v2c_msg_vec_o;
    logic               v2c_valid_o;
    logic               remap_start_i;
    logic               remap_abort_i;
    logic               remap_valid_i;
    logic               remap_ready_o;
    logic [NL*MW*BK-1:0] remap_data_vec_i;
    logic               remap_busy_o;
    logic               remap_done_o;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    int   cyc;
    int   passed;
    int   total;
    logic [3:0] lut [NL][64];
    rd_t  q [$];

    memshare_vn_iblut_rank_seq dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .rd_valid_i       (rd_valid_i),
        .rd_ready_o       (rd_ready_o),
        .col_sel_vec_i    (col_sel_vec_i),
        .c2v_msg_vec_i    (c2v_msg_vec_i),
        .v2c_msg_vec_o    (v2c_msg_vec_o),
        .v2c_valid_o      (v2c_valid_o),
        .remap_start_i    (remap_start_i),
        .remap_abort_i    (remap_abort_i),
        .remap_valid_i    (remap_valid_i),
        .remap_ready_o    (remap_ready_o),
        .remap_data_vec_i (remap_data_vec_i),
        .remap_busy_o     (remap_busy_o),
        .remap_done_o     (remap_done_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic int depth(int i);
        return CFG[i] ? 64 : 32;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        bit r;
        bit evld;
        r = rst;
        @(posedge sys_clk);
        cyc++;
        #1;
        if (r) q.delete();
        evld = (q.size() > 0) && (q[0].due == cyc);
        chk("v2c_valid", 64'(v2c_valid_o), 64'(evld));
        if (evld) begin
            chk("v2c_data", 64'(v2c_msg_vec_o), 64'(q[0].data));
            void'(q.pop_front());
        end
    endtask

    task automatic issue_read(logic [7:0] sel, logic [15:0] msg);
        rd_t e;
        int  s;
        int  a;
        rd_valid_i    = 1'b1;
        col_sel_vec_i = sel;
        c2v_msg_vec_i = msg;
        #1;
        chk("rd_ready", 64'(rd_ready_o), 64'd1);
        for (int i = 0; i < NL; i++) begin
            s = CFG[i] ? int'(sel[2*i +: 2]) : int'(sel[2*i]);
            a = s * 16 + int'(msg[4*i +: 4]);
            e.data[4*i +: 4] = lut[i][a];
        end
        e.due = cyc + RL;
        q.push_back(e);
        tick();
        rd_valid_i = 1'b0;
    endtask

    task automatic read_entry(int ent);
        logic [7:0]  sel;
        logic [15:0] msg;
        for (int i = 0; i < NL; i++) begin
            sel[2*i +: 2] = 2'(ent / 16);
            msg[4*i +: 4] = 4'(ent % 16);
        end
        issue_read(sel, msg);
    endtask

    task automatic read_rand();
        issue_read(8'($urandom), 16'($urandom));
    endtask

    // mode 0: entry a = a mod 16, 1: all 0xF, 2: random
    task automatic load(int nbeats, int mode, int fin, bit with_read);
        logic [3:0] v;
        remap_start_i = 1'b1;
        rd_valid_i    = with_read;
        #1;
        chk("rd_ready_start", 64'(rd_ready_o), 64'd0);
        tick();
        remap_start_i = 1'b0;
        rd_valid_i    = 1'b0;
        chk("remap_ready_load", 64'(remap_ready_o), 64'd1);
        chk("busy_load", 64'(remap_busy_o), 64'd1);
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < NL; i++) begin
                for (int k = 0; k < BK; k++) begin
                    v = (mode == 0) ? 4'((b * BK + k) % 16) :
                        (mode == 1) ? 4'hF : 4'($urandom);
                    remap_data_vec_i[(i*BK+k)*MW +: MW] = v;
                end
            end
            remap_valid_i = 1'b1;
            tick();
            for (int i = 0; i < NL; i++) begin
                for (int k = 0; k < BK; k++) begin
                    if (b * BK + k < depth(i)) begin
                        lut[i][b*BK+k] = remap_data_vec_i[(i*BK+k)*MW +: MW];
                    end
                end
            end
            if (b == NBEAT - 1) begin
                chk("done_pulse", 64'(remap_done_o), 64'd1);
                chk("busy_done", 64'(remap_busy_o), 64'd0);
            end else begin
                chk("busy_beat", 64'(remap_busy_o), 64'd1);
                chk("no_done", 64'(remap_done_o), 64'd0);
            end
        end
        remap_valid_i = 1'b0;
        remap_data_vec_i = '0;
        if (fin == 1) begin
            remap_valid_i = 1'b1;
            remap_abort_i = 1'b1;
            tick();
            remap_valid_i = 1'b0;
            remap_abort_i = 1'b0;
            chk("abort_busy", 64'(remap_busy_o), 64'd0);
            chk("abort_ready", 64'(remap_ready_o), 64'd0);
            chk("abort_rd_ready", 64'(rd_ready_o), 64'd1);
            tick();
            chk("abort_no_done", 64'(remap_done_o), 64'd0);
        end else if (fin == 2) begin
            remap_valid_i = 1'b1;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            remap_valid_i = 1'b0;
            #1;
            chk("rst_rd_ready", 64'(rd_ready_o), 64'd1);
            chk("rst_busy", 64'(remap_busy_o), 64'd0);
            chk("rst_remap_ready", 64'(remap_ready_o), 64'd0);
        end else begin
            tick();
            chk("post_done", 64'(remap_done_o), 64'd0);
            chk("post_rd_ready", 64'(rd_ready_o), 64'd1);
        end
    endtask

    initial begin
        cyc = 0;
        passed = 0;
        total = 0;
        rst = 1'b1;
        rd_valid_i = 1'b0;
        col_sel_vec_i = '0;
        c2v_msg_vec_i = '0;
        remap_start_i = 1'b0;
        remap_abort_i = 1'b0;
        remap_valid_i = 1'b0;
        remap_data_vec_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_rd_ready", 64'(rd_ready_o), 64'd1);
        chk("reset_remap_ready", 64'(remap_ready_o), 64'd0);
        chk("reset_busy", 64'(remap_busy_o), 64'd0);
        chk("reset_done", 64'(remap_done_o), 64'd0);
        chk("reset_v2c", 64'(v2c_msg_vec_o), 64'd0);

        load(NBEAT, 0, 0, 1'b0);

        issue_read(8'hFF, 16'h5555);
        tick();
        chk("lane0_gp1_0x15", 64'(v2c_msg_vec_o[3:0]), 64'h5);
        chk("lane1_gp2_0x35", 64'(v2c_msg_vec_o[7:4]), 64'h5);

        for (int n = 0; n < 8; n++) read_rand();
        repeat (3) tick();

        load(NBEAT, 2, 0, 1'b1);
        for (int n = 0; n < 6; n++) read_rand();
        repeat (3) tick();

        load(5, 1, 1, 1'b0);
        read_entry(0);
        read_entry(19);
        read_entry(20);
        read_entry(40);
        repeat (3) tick();

        read_rand();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        read_rand();
        load(9, 2, 2, 1'b0);
        repeat (2) tick();
        load(NBEAT, 2, 0, 1'b0);
        for (int n = 0; n < 10; n++) read_rand();
        repeat (4) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memshare_vn_iblut_rank_seq.md
Name: memshare_vn_iblut_rank_seq

Overview:
- Parametrised successor rank of VN IB-LUT lanes for the column-bank sharing scheme.
- Holds NUM_LANE lanes. Each lane is individually GP1 (1 col-sel bit) or GP2 (2 col-sel bits), set by LANE_CFG.
- Adds two things the earlier rank lacks: a sequenced, handshaked remap-load engine with bank-interleaved beats, and a pipelined read path with valid/ready and load/read arbitration.
- Sits between the layered-decoder VN update stage and the C2V/V2C message buses.

Parameters:
- NUM_LANE, 4, number of VN lanes in the rank.
- MSG_WIDTH, 4, quantisation width of C2V/V2C messages.
- GP2_COL_SEL_WIDTH, 2, col-sel width per lane slot. GP1 lanes use bit 0 only.
- LANE_CFG, 4'b1010, bit i = 1 means lane i is GP2, 0 means GP1.
- BANK_NUM, 4, interleaved entries written per remap beat. Power of two; must divide the GP1 depth.
- READ_LAT, 2, read latency in cycles (1 or 2).

Ports:
- sys_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- rd_valid_i  in  1  read request.
- rd_ready_o  out  1  read can be accepted.
- col_sel_vec_i  in  NUM_LANE*GP2_COL_SEL_WIDTH  per-lane column select.
- c2v_msg_vec_i  in  NUM_LANE*MSG_WIDTH  per-lane C2V message (low address bits).
- v2c_msg_vec_o  out  NUM_LANE*MSG_WIDTH  per-lane V2C result.
- v2c_valid_o  out  1  result valid.
- remap_start_i  in  1  begin LUT reload.
- remap_abort_i  in  1  cancel reload.
- remap_valid_i  in  1  remap beat valid.
- remap_ready_o  out  1  remap beat accepted.
- remap_data_vec_i  in  NUM_LANE*MSG_WIDTH*BANK_NUM  per-lane beat, entry k in slice k.
- remap_busy_o  out  1  load in progress.
- remap_done_o  out  1  one-cycle pulse at load completion.

Behaviour:
- Storage
  - Lane i depth D_i = 2^(MSG_WIDTH+1) for GP1, 2^(MSG_WIDTH+2) for GP2.
  - Lane address = {col_sel bits, c2v msg}. GP1 lanes ignore col_sel bit 1.
  - LUT contents are not cleared by rst.
- FSM states: IDLE, LOAD, DONE.
  - Reset: state = IDLE. All outputs 0 except rd_ready_o = 1.
  - IDLE → LOAD on remap_start_i. remap_start_i has priority over a same-cycle rd_valid_i; that read is not accepted (rd_ready_o is 0 that cycle).
  - LOAD: remap_ready_o = 1, remap_busy_o = 1, rd_ready_o = 0.
    - Each accepted beat (valid && ready) writes entries beat_cnt*BANK_NUM+k, k = 0..BANK_NUM-1, in every lane where that address < D_i.
    - GP1 lanes ignore beats past their depth.
    - beat_cnt counts 0..(D_max/BANK_NUM)-1, where D_max is the largest D_i.
    - Last accepted beat → DONE.
  - LOAD → IDLE on remap_abort_i. Abort wins over a same-cycle beat; that beat is not written. Partial contents stay written. remap_done_o is not pulsed.
  - DONE: remap_done_o = 1 for one cycle, remap_busy_o = 0, then → IDLE. beat_cnt clears to 0.
  - remap_start_i outside IDLE is ignored.
- Read path
  - rd_ready_o = 1 only in IDLE with no remap_start_i.
  - An accepted read presents v2c data and v2c_valid_o exactly READ_LAT cycles later.
  - Full throughput, one read per cycle.
  - Reads already in the pipeline when LOAD begins still complete and return pre-load data.
  - A read accepted the cycle after DONE sees the new contents.
- Reset mid-load or mid-read flushes the pipeline valids and beat_cnt and returns to IDLE. Stale v2c data may remain, but v2c_valid_o = 0.
- Widths: beat_cnt is clog2(D_max/BANK_NUM) bits, min 1. Counter wrap is never reached because the DONE transition occurs first.

Decomposition:
- Package memshare_rank_pkg:
  - state enum typedef.
  - Depth function lane_depth(cfg_bit, MSG_WIDTH).
  - D_MAX and BEAT_NUM constants.
  - Default LANE_CFG.
- Sub-module memshare_iblut_lane: one lane's register-array LUT.
  - Parameters: GP2 flag, depth, BANK_NUM, READ_LAT.
  - Contains the write-enable masking against depth.
- The FSM, beat counter and valid pipeline live in the top module.

Test Plan:
1. Reset then a full load with beat data = address (entry a = a mod 16) → remap_done_o pulses after 16 beats (D_max = 64, BANK_NUM = 4); remap_busy_o is high 16 cycles with continuous valid.
2. After load, read lane0 (GP1) col_sel = 2'b11, c2v = 4'h5 → lane0 returns entry 0x15, i.e. 4'h5, 2 cycles later. GP2 lane1 with the same input returns entry 0x35.
3. Back-to-back reads on 8 consecutive cycles → 8 consecutive v2c_valid_o cycles in order.
4. remap_start_i and rd_valid_i in the same cycle → read not accepted (rd_ready_o = 0 that cycle), remap_ready_o = 1 in the next cycle.
5. Abort after 5 beats with beat data 0xF → entries 0–19 read 0xF, entry 20 keeps its old value, no done pulse.
6. Assert rst during beat 9 → FSM back in IDLE, v2c_valid_o = 0, next remap_start_i restarts the load at beat 0.
